// File: rtl/mips_defs.sv
// Shared definitions for the MIPS-style datapath: word/operand widths,
// ALU opcode constants and the register-file access FSM encoding.
package mips_defs;

    localparam int WORD_SIZE = 16;
    localparam int OP_SIZE   = 4;

    // ALU opcodes decoded by alu_control.
    localparam logic [3:0] ADD  = 4'h0;
    localparam logic [3:0] SUB  = 4'h1;
    localparam logic [3:0] AND  = 4'h2;
    localparam logic [3:0] OR   = 4'h3;
    localparam logic [3:0] SLT  = 4'h4;
    localparam logic [3:0] BEQ  = 4'h5;
    localparam logic [3:0] JUMP = 4'h6;

    // Register-file access handshake states.
    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } acc_state_t;

endpackage

// File: rtl/reg_bank_ram.sv
// Register storage: 2**ADDR_W words of WIDTH bits, one synchronous write
// port and three combinational read ports, cleared by reset.
module reg_bank_ram #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr_0,
    input  logic [ADDR_W-1:0] raddr_1,
    input  logic [ADDR_W-1:0] raddr_2,
    output logic [WIDTH-1:0]  rdata_0,
    output logic [WIDTH-1:0]  rdata_1,
    output logic [WIDTH-1:0]  rdata_2
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage update: clear on reset, otherwise write one word when enabled.
    // NOTE: this array is reset on purpose -- registers must read 0 after reset,
    // so it is built from flops; an array mapped to RAM macros could not be reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            // NOTE: non-blocking so every reader this edge sees the pre-write value.
            mem[waddr] <= wdata;
        end
    end

    assign rdata_0 = mem[raddr_0];
    assign rdata_1 = mem[raddr_1];
    assign rdata_2 = mem[raddr_2];

endmodule

// File: rtl/reg_file_responder.sv
// 16-entry register file: responder side of the reg_on/reg_w access handshake
// plus two registered operand read ports with write-through bypass.
module reg_file_responder
    import mips_defs::*;
#(
    parameter bit ZERO_R0 = 1'b1
) (
    input  logic                 tclk,
    input  logic                 rst_n,
    input  logic                 reg_on,
    input  logic                 reg_w,
    input  logic [OP_SIZE-1:0]   reg_addr,
    input  logic [WORD_SIZE-1:0] reg_data_in,
    output logic [WORD_SIZE-1:0] reg_data_out,
    output logic                 reg_ack,
    input  logic [OP_SIZE-1:0]   rd_addr_1,
    input  logic [OP_SIZE-1:0]   rd_addr_2,
    output logic [WORD_SIZE-1:0] rd_data_1,
    output logic [WORD_SIZE-1:0] rd_data_2
);

    acc_state_t           state_q, state_d;
    logic                 accept, wr_en, rd_en;
    logic [WORD_SIZE-1:0] ram_acc, ram_rd_1, ram_rd_2;
    logic [WORD_SIZE-1:0] acc_next, rd_next_1, rd_next_2;

    // Requests are only taken in IDLE; R0 writes are acked but never stored.
    assign accept = (state_q == IDLE) && reg_on;
    assign wr_en  = accept && reg_w && !(ZERO_R0 && (reg_addr == '0));
    assign rd_en  = accept && !reg_w;

    reg_bank_ram #(
        .WIDTH  (WORD_SIZE),
        .ADDR_W (OP_SIZE)
    ) u_bank (
        .clk     (tclk),
        .rst_n   (rst_n),
        .we      (wr_en),
        .waddr   (reg_addr),
        .wdata   (reg_data_in),
        .raddr_0 (reg_addr),
        .raddr_1 (rd_addr_1),
        .raddr_2 (rd_addr_2),
        .rdata_0 (ram_acc),
        .rdata_1 (ram_rd_1),
        .rdata_2 (ram_rd_2)
    );

    // Access FSM state register.
    always_ff @(posedge tclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Access FSM next state: one accepted request always spends one cycle in ACK.
    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (reg_on) state_d = ACK;
            ACK:  state_d = IDLE;
        endcase
    end

    assign reg_ack = (state_q == ACK);

    // Operand/access read values: forward same-edge write data, force R0 to zero.
    // wr_en already excludes R0, so the bypass can never forward to it.
    always_comb begin
        acc_next  = ram_acc;
        rd_next_1 = ram_rd_1;
        rd_next_2 = ram_rd_2;
        if (wr_en && (rd_addr_1 == reg_addr)) rd_next_1 = reg_data_in;
        if (wr_en && (rd_addr_2 == reg_addr)) rd_next_2 = reg_data_in;
        if (ZERO_R0 && (reg_addr == '0))  acc_next  = '0;
        if (ZERO_R0 && (rd_addr_1 == '0)) rd_next_1 = '0;
        if (ZERO_R0 && (rd_addr_2 == '0)) rd_next_2 = '0;
    end

    // Output registers: operand ports load every edge, access port only on a read.
    always_ff @(posedge tclk or negedge rst_n) begin
        if (!rst_n) begin
            reg_data_out <= '0;
            rd_data_1    <= '0;
            rd_data_2    <= '0;
        end else begin
            rd_data_1 <= rd_next_1;
            rd_data_2 <= rd_next_2;
            if (rd_en) begin
                reg_data_out <= acc_next;
            end
        end
    end

endmodule

// File: tb/tb_reg_file_responder.sv
// Directed bench for reg_file_responder: a vector table for the main access and
// operand behaviour, then hand sequences for back-to-back reads and resets.
// A second instance with ZERO_R0=0 shares all inputs.
module tb_reg_file_responder;

    logic        tclk;
    logic        rst_n;
    logic        reg_on, reg_w;
    logic [3:0]  reg_addr, rd_addr_1, rd_addr_2;
    logic [15:0] reg_data_in;
    logic [15:0] reg_data_out, rd_data_1, rd_data_2;
    logic        reg_ack;
    logic [15:0] nz_data_out, nz_rd_1, nz_rd_2;
    logic        nz_ack;

    int n_vec = 0;
    int n_err = 0;

    reg_file_responder #(.ZERO_R0(1'b1)) dut (
        .tclk(tclk), .rst_n(rst_n), .reg_on(reg_on), .reg_w(reg_w),
        .reg_addr(reg_addr), .reg_data_in(reg_data_in),
        .reg_data_out(reg_data_out), .reg_ack(reg_ack),
        .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2),
        .rd_data_1(rd_data_1), .rd_data_2(rd_data_2)
    );

    reg_file_responder #(.ZERO_R0(1'b0)) dut_nz (
        .tclk(tclk), .rst_n(rst_n), .reg_on(reg_on), .reg_w(reg_w),
        .reg_addr(reg_addr), .reg_data_in(reg_data_in),
        .reg_data_out(nz_data_out), .reg_ack(nz_ack),
        .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2),
        .rd_data_1(nz_rd_1), .rd_data_2(nz_rd_2)
    );

    initial tclk = 1'b0;
    always #5 tclk = ~tclk;

    typedef struct {
        logic        on;
        logic        w;
        logic [3:0]  addr;
        logic [15:0] din;
        logic [3:0]  ra1;
        logic [3:0]  ra2;
        logic        ack;
        logic [15:0] out;
        logic [15:0] rd1;
        logic [15:0] rd2;
        logic [15:0] out_nz;
        logic [15:0] rd1_nz;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one rising edge and settle just past it.
    task automatic tick();
        @(posedge tclk);
        #1;
    endtask

    task automatic drive(input logic on, input logic w, input logic [3:0] a,
                         input logic [15:0] d, input logic [3:0] r1, input logic [3:0] r2);
        reg_on = on; reg_w = w; reg_addr = a; reg_data_in = d;
        rd_addr_1 = r1; rd_addr_2 = r2;
    endtask

    int          n_ack;
    logic [3:0]  b2b_addr [3];
    logic [15:0] b2b_val  [3];

    initial begin
        //            on w  addr din      ra1 ra2 ack out      rd1      rd2      out_nz   rd1_nz
        vecs[0]  = '{1, 1, 3, 16'h1234, 3, 0, 1, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 16'h1234};
        vecs[1]  = '{1, 1, 3, 16'h1234, 3, 0, 0, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 16'h1234};
        vecs[2]  = '{0, 0, 0, 16'h0000, 3, 5, 0, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 16'h1234};
        vecs[3]  = '{1, 1, 5, 16'hA5A5, 5, 3, 1, 16'h0000, 16'hA5A5, 16'h1234, 16'h0000, 16'hA5A5};
        vecs[4]  = '{0, 0, 0, 16'h0000, 5, 5, 0, 16'h0000, 16'hA5A5, 16'hA5A5, 16'h0000, 16'hA5A5};
        vecs[5]  = '{1, 0, 3, 16'h0000, 0, 0, 1, 16'h1234, 16'h0000, 16'h0000, 16'h1234, 16'h0000};
        vecs[6]  = '{1, 0, 5, 16'h0000, 0, 0, 0, 16'h1234, 16'h0000, 16'h0000, 16'h1234, 16'h0000};
        vecs[7]  = '{1, 0, 5, 16'h0000, 0, 0, 1, 16'hA5A5, 16'h0000, 16'h0000, 16'hA5A5, 16'h0000};
        vecs[8]  = '{0, 0, 0, 16'h0000, 0, 0, 0, 16'hA5A5, 16'h0000, 16'h0000, 16'hA5A5, 16'h0000};
        vecs[9]  = '{1, 1, 7, 16'hBEEF, 7, 7, 1, 16'hA5A5, 16'hBEEF, 16'hBEEF, 16'hA5A5, 16'hBEEF};
        vecs[10] = '{0, 0, 0, 16'h0000, 7, 0, 0, 16'hA5A5, 16'hBEEF, 16'h0000, 16'hA5A5, 16'hBEEF};
        vecs[11] = '{1, 1, 0, 16'hFFFF, 0, 0, 1, 16'hA5A5, 16'h0000, 16'h0000, 16'hA5A5, 16'hFFFF};
        vecs[12] = '{0, 0, 0, 16'h0000, 0, 0, 0, 16'hA5A5, 16'h0000, 16'h0000, 16'hA5A5, 16'hFFFF};
        vecs[13] = '{1, 0, 0, 16'h0000, 0, 0, 1, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF};
        vecs[14] = '{0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF};

        b2b_addr[0] = 4'd3; b2b_val[0] = 16'h1234;
        b2b_addr[1] = 4'd5; b2b_val[1] = 16'hA5A5;
        b2b_addr[2] = 4'd7; b2b_val[2] = 16'hBEEF;

        // Power-on reset.
        rst_n = 1'b0;
        drive(0, 0, 0, 16'h0000, 0, 0);
        #2;
        check("por_ack", {15'd0, reg_ack}, 16'h0000);
        check("por_out", reg_data_out, 16'h0000);
        tick();
        tick();
        rst_n = 1'b1;

        // Table: writes, bypass, reads, R0 handling.
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].on, vecs[i].w, vecs[i].addr, vecs[i].din, vecs[i].ra1, vecs[i].ra2);
            tick();
            check($sformatf("v%0d_ack", i), {15'd0, reg_ack}, {15'd0, vecs[i].ack});
            check($sformatf("v%0d_out", i), reg_data_out, vecs[i].out);
            check($sformatf("v%0d_rd1", i), rd_data_1, vecs[i].rd1);
            check($sformatf("v%0d_rd2", i), rd_data_2, vecs[i].rd2);
            check($sformatf("v%0d_nz_out", i), nz_data_out, vecs[i].out_nz);
            check($sformatf("v%0d_nz_rd1", i), nz_rd_1, vecs[i].rd1_nz);
        end

        // Back-to-back reads with reg_on held: one access every other cycle.
        n_ack = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1, 0, b2b_addr[i/2], 16'h0000, 0, 0);
            tick();
            if (reg_ack) n_ack++;
            check($sformatf("b2b%0d_ack", i), {15'd0, reg_ack}, (i % 2 == 0) ? 16'h0001 : 16'h0000);
            if (i % 2 == 0) check($sformatf("b2b%0d_out", i), reg_data_out, b2b_val[i/2]);
        end
        check("b2b_ack_count", 16'(n_ack), 16'd3);

        // Async reset mid-run: all outputs drop at once; R5 reads 0 afterwards.
        drive(0, 0, 0, 16'h0000, 7, 3);
        tick();
        check("pre_rst_rd1", rd_data_1, 16'hBEEF);
        rst_n = 1'b0;
        #1;
        check("rst_out", reg_data_out, 16'h0000);
        check("rst_rd1", rd_data_1, 16'h0000);
        check("rst_rd2", rd_data_2, 16'h0000);
        check("rst_ack", {15'd0, reg_ack}, 16'h0000);
        tick();
        rst_n = 1'b1;
        drive(1, 0, 5, 16'h0000, 0, 0);
        tick();
        check("post_rst_r5_ack", {15'd0, reg_ack}, 16'h0001);
        check("post_rst_r5_out", reg_data_out, 16'h0000);
        drive(0, 0, 0, 16'h0000, 0, 0);
        tick();

        // Reset between request edge and ack consumption: ack lost, write lost.
        drive(1, 1, 9, 16'h5555, 9, 0);
        tick();
        check("r9_bypass", rd_data_1, 16'h5555);
        rst_n = 1'b0;
        #1;
        check("midacc_ack", {15'd0, reg_ack}, 16'h0000);
        drive(0, 0, 0, 16'h0000, 9, 0);
        tick();
        check("midacc_ack_held", {15'd0, reg_ack}, 16'h0000);
        rst_n = 1'b1;
        tick();
        check("midacc_ack_after", {15'd0, reg_ack}, 16'h0000);
        check("midacc_r9_rd1", rd_data_1, 16'h0000);
        drive(1, 0, 9, 16'h0000, 9, 0);
        tick();
        check("midacc_r9_ack", {15'd0, reg_ack}, 16'h0001);
        check("midacc_r9_out", reg_data_out, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
